// File: rtl/histogram_esleme_uygulayici_pkg.sv
// Shared constants and state encoding for the histogram-equalization table applier.
package histogram_esleme_uygulayici_pkg;

    localparam int unsigned VARSAYILAN_PIXEL_BIT      = 8;
    localparam int unsigned VARSAYILAN_CERCEVE_PIKSEL = 76800;
    localparam int unsigned VARSAYILAN_SAYAC_BIT      = 17;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef enum logic [1:0] {
        StBos   = 2'd0,
        StYukle = 2'd1,
        StEsle  = 2'd2
    } durum_e;

endpackage

// File: rtl/histogram_esleme_uygulayici_tablosu.sv
// Mapping table: one write port, one enabled read port with a registered output
// that holds its value while the read enable is low. Contents are never reset.
module histogram_esleme_uygulayici_tablosu
    import histogram_esleme_uygulayici_pkg::*;
#(
    parameter int unsigned PIXEL_BIT = VARSAYILAN_PIXEL_BIT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 yaz_i,
    input  logic [PIXEL_BIT-1:0] yaz_adres_i,
    input  logic [PIXEL_BIT-1:0] yaz_veri_i,
    input  logic                 oku_i,
    input  logic [PIXEL_BIT-1:0] oku_adres_i,
    output logic [PIXEL_BIT-1:0] oku_veri_o
);

    localparam int unsigned DERINLIK = 2 ** PIXEL_BIT;

    logic [PIXEL_BIT-1:0] bellek_q [DERINLIK];
    logic [PIXEL_BIT-1:0] oku_veri_q, oku_veri_d;

    always_ff @(posedge clk_i) begin
        if (yaz_i) begin
            bellek_q[yaz_adres_i] <= yaz_veri_i;
        end
    end

    always_comb begin
        oku_veri_d = oku_veri_q;
        if (oku_i) begin
            oku_veri_d = bellek_q[oku_adres_i];
        end
    end

    // Only the output register is reset so the equalized pixel starts at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oku_veri_q <= '0;
        end else begin
            oku_veri_q <= oku_veri_d;
        end
    end

    assign oku_veri_o = oku_veri_q;

endmodule

// File: rtl/histogram_esleme_uygulayici.sv
// Loads the equalizer's (pixel, result) pairs into a lookup table, then maps one
// frame of raw pixels through it with valid/ready flow control on both sides.
module histogram_esleme_uygulayici
    import histogram_esleme_uygulayici_pkg::*;
#(
    parameter int unsigned PIXEL_BIT      = VARSAYILAN_PIXEL_BIT,
    parameter int unsigned CERCEVE_PIKSEL = VARSAYILAN_CERCEVE_PIKSEL,
    parameter int unsigned SAYAC_BIT      = VARSAYILAN_SAYAC_BIT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 lut_etkin_i,
    input  logic [PIXEL_BIT-1:0] lut_pixel_i,
    input  logic [PIXEL_BIT-1:0] lut_sonuc_i,
    input  logic                 lut_tamam_i,
    input  logic                 pixel_gecerli_i,
    input  logic [PIXEL_BIT-1:0] pixel_i,
    output logic                 pixel_hazir_o,
    output logic                 pixel_gecerli_o,
    output logic [PIXEL_BIT-1:0] pixel_o,
    output logic                 cerceve_son_o,
    input  logic                 pixel_hazir_i,
    output logic                 tablo_hazir_o,
    output logic                 hata_o
);

    localparam int unsigned DERINLIK = 2 ** PIXEL_BIT;
    localparam logic [SAYAC_BIT-1:0] CERCEVE_BOYU = SAYAC_BIT'(CERCEVE_PIKSEL);
    localparam logic [SAYAC_BIT-1:0] SON_INDIS    = SAYAC_BIT'(CERCEVE_PIKSEL - 1);

    durum_e               durum_q, durum_d;
    logic [DERINLIK-1:0]  maske_q, maske_d, maske_yaz;
    logic [SAYAC_BIT-1:0] kabul_sayac_q, kabul_sayac_d;
    logic                 s1_gecerli_q, s1_gecerli_d;
    logic [PIXEL_BIT-1:0] s1_adres_q, s1_adres_d;
    logic                 s1_son_q, s1_son_d;
    logic                 cikis_gecerli_q, cikis_gecerli_d;
    logic                 cikis_son_q, cikis_son_d;
    logic                 tablo_hazir_q, tablo_hazir_d;
    logic                 hata_q, hata_d;

    logic                 ilerle;
    logic                 kabul;
    logic                 teslim;
    logic                 tablo_yaz;
    logic                 tablo_oku;
    logic [PIXEL_BIT-1:0] tablo_veri;

    assign ilerle        = !cikis_gecerli_q || pixel_hazir_i;
    assign pixel_hazir_o = (durum_q == StEsle) && ilerle && (kabul_sayac_q < CERCEVE_BOYU);
    assign kabul         = pixel_gecerli_i && pixel_hazir_o;
    assign teslim        = cikis_gecerli_q && pixel_hazir_i;
    assign tablo_yaz     = lut_etkin_i && (durum_q != StEsle);
    // Read only when stage 1 holds a pixel so pixel_o stays put on bubbles and stalls.
    assign tablo_oku     = ilerle && s1_gecerli_q;

    always_comb begin
        maske_yaz = '0;
        if (tablo_yaz) begin
            maske_yaz[lut_pixel_i] = HIGH;
        end
    end

    always_comb begin
        durum_d         = durum_q;
        maske_d         = maske_q | maske_yaz;
        kabul_sayac_d   = kabul_sayac_q;
        s1_gecerli_d    = s1_gecerli_q;
        s1_adres_d      = s1_adres_q;
        s1_son_d        = s1_son_q;
        cikis_gecerli_d = cikis_gecerli_q;
        cikis_son_d     = cikis_son_q;
        hata_d          = hata_q;

        case (durum_q)
            StBos: begin
                if (lut_etkin_i) begin
                    durum_d = StYukle;
                end
            end
            StYukle: begin
                // maske_d already includes a write landing in the same cycle.
                if (lut_tamam_i) begin
                    durum_d = StEsle;
                    if (!(&maske_d)) begin
                        hata_d = HIGH;
                    end
                end
            end
            StEsle: begin
                if (lut_etkin_i) begin
                    hata_d = HIGH;
                end
                if (ilerle) begin
                    s1_gecerli_d    = kabul;
                    s1_son_d        = kabul && (kabul_sayac_q == SON_INDIS);
                    cikis_gecerli_d = s1_gecerli_q;
                    cikis_son_d     = s1_son_q;
                    if (kabul) begin
                        s1_adres_d = pixel_i;
                    end
                end
                if (kabul) begin
                    kabul_sayac_d = kabul_sayac_q + SAYAC_BIT'(1);
                end
                // The last beat can only leave once every earlier pixel has gone.
                if (teslim && cikis_son_q) begin
                    durum_d       = StBos;
                    maske_d       = '0;
                    kabul_sayac_d = '0;
                end
            end
            default: begin
                durum_d = StBos;
            end
        endcase

        tablo_hazir_d = (durum_d == StEsle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q         <= StBos;
            maske_q         <= '0;
            kabul_sayac_q   <= '0;
            s1_gecerli_q    <= LOW;
            s1_adres_q      <= '0;
            s1_son_q        <= LOW;
            cikis_gecerli_q <= LOW;
            cikis_son_q     <= LOW;
            tablo_hazir_q   <= LOW;
            hata_q          <= LOW;
        end else begin
            durum_q         <= durum_d;
            maske_q         <= maske_d;
            kabul_sayac_q   <= kabul_sayac_d;
            s1_gecerli_q    <= s1_gecerli_d;
            s1_adres_q      <= s1_adres_d;
            s1_son_q        <= s1_son_d;
            cikis_gecerli_q <= cikis_gecerli_d;
            cikis_son_q     <= cikis_son_d;
            tablo_hazir_q   <= tablo_hazir_d;
            hata_q          <= hata_d;
        end
    end

    histogram_esleme_uygulayici_tablosu #(
        .PIXEL_BIT (PIXEL_BIT)
    ) u_tablo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .yaz_i       (tablo_yaz),
        .yaz_adres_i (lut_pixel_i),
        .yaz_veri_i  (lut_sonuc_i),
        .oku_i       (tablo_oku),
        .oku_adres_i (s1_adres_q),
        .oku_veri_o  (tablo_veri)
    );

    assign pixel_gecerli_o = cikis_gecerli_q;
    assign pixel_o         = tablo_veri;
    assign cerceve_son_o   = cikis_gecerli_q && cikis_son_q;
    assign tablo_hazir_o   = tablo_hazir_q;
    assign hata_o          = hata_q;

endmodule

// File: tb/tb_histogram_esleme_uygulayici.sv
// Directed bench for the table applier, built with a 4-pixel frame.
module tb_histogram_esleme_uygulayici;

    localparam int unsigned FRAME = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       lut_etkin_i;
    logic [7:0] lut_pixel_i;
    logic [7:0] lut_sonuc_i;
    logic       lut_tamam_i;
    logic       pixel_gecerli_i;
    logic [7:0] pixel_i;
    logic       pixel_hazir_o;
    logic       pixel_gecerli_o;
    logic [7:0] pixel_o;
    logic       cerceve_son_o;
    logic       pixel_hazir_i;
    logic       tablo_hazir_o;
    logic       hata_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int in_q[$];
    int exp_q[$];

    always #5 clk_i = ~clk_i;

    histogram_esleme_uygulayici #(
        .PIXEL_BIT      (8),
        .CERCEVE_PIKSEL (FRAME),
        .SAYAC_BIT      (17)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lut_etkin_i     (lut_etkin_i),
        .lut_pixel_i     (lut_pixel_i),
        .lut_sonuc_i     (lut_sonuc_i),
        .lut_tamam_i     (lut_tamam_i),
        .pixel_gecerli_i (pixel_gecerli_i),
        .pixel_i         (pixel_i),
        .pixel_hazir_o   (pixel_hazir_o),
        .pixel_gecerli_o (pixel_gecerli_o),
        .pixel_o         (pixel_o),
        .cerceve_son_o   (cerceve_son_o),
        .pixel_hazir_i   (pixel_hazir_i),
        .tablo_hazir_o   (tablo_hazir_o),
        .hata_o          (hata_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_reset_values();
        chk("rst_hazir", pixel_hazir_o, 0);
        chk("rst_gecerli", pixel_gecerli_o, 0);
        chk("rst_pixel", pixel_o, 0);
        chk("rst_son", cerceve_son_o, 0);
        chk("rst_tablo", tablo_hazir_o, 0);
        chk("rst_hata", hata_o, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // birlesik: the final write shares its cycle with the tamam pulse.
    task automatic load(input bit ters, input int adet, input bit birlesik);
        for (int i = 0; i < adet; i++) begin
            lut_etkin_i = 1'b1;
            lut_pixel_i = 8'(i);
            lut_sonuc_i = ters ? 8'(255 - i) : 8'(i);
            lut_tamam_i = birlesik && (i == adet - 1);
            tick();
        end
        lut_etkin_i = 1'b0;
        if (!birlesik) begin
            lut_tamam_i = 1'b1;
            tick();
        end
        lut_tamam_i = 1'b0;
    endtask

    task automatic stream(input int stall_start);
        int ii = 0;
        int oi = 0;
        int cyc = 0;
        int first_v = -1;
        logic [7:0] held = '0;
        while (oi < exp_q.size() && cyc < 200) begin
            pixel_gecerli_i = (ii < in_q.size());
            pixel_i         = (ii < in_q.size()) ? 8'(in_q[ii]) : 8'd0;
            pixel_hazir_i   = !(cyc >= stall_start && cyc < stall_start + 5);
            #1;
            if (pixel_gecerli_o && first_v < 0) first_v = cyc;
            if (!pixel_hazir_i) begin
                chk("stall_hazir", pixel_hazir_o, 0);
                chk("stall_gecerli", pixel_gecerli_o, 1);
                if (cyc > stall_start) chk("stall_hold", pixel_o, held);
                held = pixel_o;
            end
            if (ii >= FRAME) chk("hazir_full", pixel_hazir_o, 0);
            if (pixel_gecerli_o && pixel_hazir_i) begin
                chk("out_pixel", pixel_o, exp_q[oi]);
                chk("out_son", cerceve_son_o, (oi == FRAME - 1) ? 1 : 0);
                oi++;
            end
            if (pixel_gecerli_i && pixel_hazir_o) ii++;
            tick();
            cyc++;
        end
        pixel_gecerli_i = 1'b0;
        pixel_hazir_i   = 1'b1;
        chk("stream_count", oi, exp_q.size());
        chk("latency", first_v, 2);
        chk("end_tablo", tablo_hazir_o, 0);
        chk("end_gecerli", pixel_gecerli_o, 0);
    endtask

    initial begin
        int seen;
        rst_i           = 1'b0;
        lut_etkin_i     = 1'b0;
        lut_pixel_i     = '0;
        lut_sonuc_i     = '0;
        lut_tamam_i     = 1'b0;
        pixel_gecerli_i = 1'b0;
        pixel_i         = '0;
        pixel_hazir_i   = 1'b1;

        do_reset();
        check_reset_values();

        // Identity table.
        load(1'b0, 256, 1'b0);
        chk("id_tablo", tablo_hazir_o, 1);
        chk("id_hata", hata_o, 0);
        in_q  = '{0, 17, 255, 100};
        exp_q = '{0, 17, 255, 100};
        stream(1000);

        // Inverting table, frame end behaviour.
        load(1'b1, 256, 1'b0);
        chk("inv_hata", hata_o, 0);
        in_q  = '{10, 20, 30, 40};
        exp_q = '{245, 235, 225, 215};
        stream(1000);

        // Last write coincides with tamam: mask must count it.
        load(1'b1, 256, 1'b1);
        chk("merge_tablo", tablo_hazir_o, 1);
        chk("merge_hata", hata_o, 0);
        in_q  = '{1, 2, 3, 4};
        exp_q = '{254, 253, 252, 251};
        stream(3);

        // Incomplete load: 255 keeps the inverted value 0.
        load(1'b0, 255, 1'b0);
        chk("part_hata", hata_o, 1);
        chk("part_tablo", tablo_hazir_o, 1);
        in_q  = '{255, 254, 7, 0};
        exp_q = '{0, 254, 7, 0};
        stream(1000);

        // Write during mapping is dropped and flags an error.
        do_reset();
        chk("rst2_hata", hata_o, 0);
        load(1'b0, 256, 1'b0);
        chk("esle_hata_pre", hata_o, 0);
        lut_etkin_i = 1'b1;
        lut_pixel_i = 8'd5;
        lut_sonuc_i = 8'd99;
        tick();
        lut_etkin_i = 1'b0;
        chk("esle_hata", hata_o, 1);
        chk("esle_tablo", tablo_hazir_o, 1);
        in_q  = '{5, 6, 7, 8};
        exp_q = '{5, 6, 7, 8};
        stream(1000);

        // Reset with two pixels in flight.
        load(1'b0, 256, 1'b0);
        pixel_hazir_i   = 1'b0;
        pixel_gecerli_i = 1'b1;
        pixel_i         = 8'd9;
        tick();
        pixel_i = 8'd10;
        tick();
        pixel_gecerli_i = 1'b0;
        chk("flight_gecerli", pixel_gecerli_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        pixel_hazir_i = 1'b1;
        check_reset_values();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pixel_gecerli_o) seen++;
        end
        chk("flush", seen, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
